cpu_clkgen: RTL and testbench
=============================

# cpu_clkgen

Parametrised CPU clock and frame-timing generator for the Spectrum core, running entirely in the `clk_sys` domain.
- Produces the CPU clock level and its edge strobes, with selectable turbo multiples and an optional contention stall.
- Provides a fixed-rate PSG enable, a base-rate T-state frame counter and the vertical-retrace interrupt.
- Replaces the fixed two-speed `clk_cpu2x` divider and sits between the PLL counter and the CPU/ULA.

## Interface
- `HALF_BASE`, 4: `clk_sys` cycles per CPU half-period at 1x (28 MHz / 8 = 3.5 MHz).
- `TURBO_W`, 2: width of the turbo select.
- `PSG_DIV`, 16: `clk_sys` cycles per `psg_en` pulse (1.75 MHz).
- `FRAME_T`, 69888: base T-states per frame (use 70908 for 128K).
- `INT_LEN`, 32: base T-states `vs_nintr` is held low.
- `TW`, 17: width of `tstate`.

Ports:
- `clk_sys` in 1: the only clock, 28 MHz.
- `nRESET` in 1: synchronous, active-low reset.
- `turbo` in TURBO_W: requested speed, 2^turbo × base.
- `stall` in 1: contention request, active high.
- `clk_cpu` out 1: registered CPU clock level.
- `cpu_pos` out 1: one-cycle strobe in the cycle `clk_cpu` becomes 1.
- `cpu_neg` out 1: one-cycle strobe in the cycle `clk_cpu` becomes 0.
- `psg_en` out 1: one-cycle strobe every PSG_DIV cycles.
- `tstate` out TW: base-rate T-state within the frame, 0..FRAME_T-1.
- `vs_nintr` out 1: active-low interrupt.
- `turbo_act` out TURBO_W: turbo value currently applied.

## Operation
- Effective half-period H = max(1, HALF_BASE >> turbo_act). Requests beyond the limit clamp to H = 1. With defaults: turbo 0→4, 1→2, 2→1, 3→1.
- Half-period counter `hcnt` runs 0..H-1. When `hcnt` == H-1:
  - toggle `clk_cpu`;
  - clear `hcnt`;
  - assert `cpu_pos` or `cpu_neg` for the direction of the toggle.
- Turbo changes apply only on a low→high toggle, i.e. at the start of a full CPU cycle.
  - `turbo` is sampled in that cycle into `turbo_act`.
  - The new H governs the high phase that begins there.
  - A change at any other time waits; no runt phases are produced.
- Stall (contention):
  - If `clk_cpu` = 1, `hcnt` == H-1 and `stall` = 1: no toggle, `hcnt` holds, and `clk_cpu` stays high.
  - The falling edge occurs in the first cycle `stall` is sampled 0.
  - `stall` is ignored while `clk_cpu` = 0, and before the end of the high phase.
- Base tick: a separate counter `bcnt` runs 0..2·HALF_BASE-1 and ticks on wrap.
  - `tstate` increments on each tick and wraps FRAME_T-1 → 0.
  - It is unaffected by turbo and by stall.
- `vs_nintr` is registered: 0 when `tstate` < INT_LEN, otherwise 1.
- `psg_en` comes from a free-running counter 0..PSG_DIV-1 and pulses at PSG_DIV-1. It is independent of turbo and stall.

## Timing
Reset values:
- `clk_cpu` = 0, `cpu_pos` = 0, `cpu_neg` = 0, `psg_en` = 0.
- `tstate` = 0, `vs_nintr` = 1, `turbo_act` = 0.
- All internal counters = 0.

After reset release:
- First `cpu_pos` occurs in cycle HALF_BASE, counting the first cycle after release as cycle 1.
- `vs_nintr` falls in the first cycle after release, and stays low for INT_LEN·2·HALF_BASE cycles.
- First `psg_en` occurs at cycle PSG_DIV.

Pulse and edge rules:
- Strobes are registered alongside `clk_cpu`, so a strobe coincides with the new level.
- `cpu_pos` and `cpu_neg` are never both 1.
- At 1x the CPU period is 8 cycles: 4 high, 4 low, unless stalled.

Boundary conditions:
- A turbo change and a stall in the same cycle: the stall governs the current high phase; the turbo change waits for the next rising edge.
- Reset mid-stall or mid-phase: all state returns to reset values on the next edge; no strobe is emitted in that cycle.
- The `tstate` wrap and the `vs_nintr` fall occur in consecutive cycles.
- FRAME_T must be greater than INT_LEN.

## Configuration
- `CPUCLK_CONTENTION_EN` defined: `stall` behaves as described above.
- Not defined:
  - `stall` is ignored; the port remains, unused.
  - The high phase always lasts exactly H cycles.
  - All other behaviour is identical.

## Test plan
- Reset held 5 cycles, then released, turbo = 0:
  - all outputs equal their reset values during reset;
  - `cpu_pos` at cycle 4, `cpu_neg` at 8, `cpu_pos` at 12;
  - `psg_en` at 16, 32.
- turbo 0 → 1 mid high phase:
  - the current CPU cycle completes at 8 cycles;
  - after the next `cpu_pos`, `turbo_act` = 1 and the period is 4;
  - turbo = 3 gives period 2 (clamped).
- Macro defined, `stall` = 1 for 6 cycles from the last high-phase cycle:
  - `clk_cpu` stays 1 for 4 + 6 cycles;
  - `cpu_neg` fires in the cycle after `stall` drops;
  - `tstate` and `psg_en` cadence are unchanged.
- Macro undefined, same stimulus: the high phase stays 4 cycles.
- FRAME_T = 10, INT_LEN = 2, HALF_BASE = 4:
  - `tstate` counts 0..9 and wraps every 80 cycles;
  - `vs_nintr` is low for 16 cycles per frame.
- Reset asserted during a stall: next cycle `clk_cpu` = 0, `tstate` = 0, `turbo_act` = 0.

Source files
------------

// File: rtl/cpu_clkgen_if.sv
// CPU clock generator bus: speed/contention requests in, CPU clock, strobes and
// frame timing out. The generator drives through the master modport.
interface cpu_clkgen_if #(
  parameter int unsigned TURBO_W = 2,
  parameter int unsigned TW      = 17
);
  logic [TURBO_W-1:0] turbo;
  logic               stall;
  logic               clk_cpu;
  logic               cpu_pos;
  logic               cpu_neg;
  logic               psg_en;
  logic [TW-1:0]      tstate;
  logic               vs_nintr;
  logic [TURBO_W-1:0] turbo_act;

  modport master (
    input  turbo, stall,
    output clk_cpu, cpu_pos, cpu_neg, psg_en, tstate, vs_nintr, turbo_act
  );

  modport slave (
    output turbo, stall,
    input  clk_cpu, cpu_pos, cpu_neg, psg_en, tstate, vs_nintr, turbo_act
  );
endinterface

// File: rtl/cpu_clkgen.sv
// CPU clock and frame-timing generator, single clk_sys domain.
// Optional contention stall is enabled by defining CPUCLK_CONTENTION_EN;
// without it the stall input is ignored and the high phase is always H cycles.
module cpu_clkgen #(
  parameter int unsigned HALF_BASE = 4,
  parameter int unsigned TURBO_W   = 2,
  parameter int unsigned PSG_DIV   = 16,
  parameter int unsigned FRAME_T   = 69888,
  parameter int unsigned INT_LEN   = 32,
  parameter int unsigned TW        = 17
) (
  input logic           clk_sys,
  input logic           nRESET,
  cpu_clkgen_if.master  bus
);

  localparam int unsigned HW = (HALF_BASE > 1) ? $clog2(HALF_BASE) : 1;
  localparam int unsigned BW = $clog2(2 * HALF_BASE);
  localparam int unsigned PW = (PSG_DIV > 1) ? $clog2(PSG_DIV) : 1;

  logic [HW-1:0]      hcnt_q, hcnt_d;
  logic               clk_cpu_q, clk_cpu_d;
  logic               cpu_pos_q, cpu_pos_d;
  logic               cpu_neg_q, cpu_neg_d;
  logic [TURBO_W-1:0] turbo_act_q, turbo_act_d;
  logic [BW-1:0]      bcnt_q, bcnt_d;
  logic [TW-1:0]      tstate_q, tstate_d;
  logic               vs_nintr_q, vs_nintr_d;
  logic [PW-1:0]      pcnt_q, pcnt_d;
  logic               psg_en_q, psg_en_d;

  logic [31:0]        h_eff;
  logic [HW-1:0]      h_last;
  logic               stall_hold;
  logic               base_tick;

`ifdef CPUCLK_CONTENTION_EN
  // Contention only stretches the end of the high phase.
  assign stall_hold = clk_cpu_q & bus.stall;
`else
  logic unused_stall;
  assign unused_stall = bus.stall;
  assign stall_hold   = 1'b0;
`endif

  // Effective half-period from the applied turbo, clamped to at least one cycle.
  always_comb begin
    h_eff = 32'(HALF_BASE) >> turbo_act_q;
    if (h_eff == 32'd0) h_eff = 32'd1;
    h_last = HW'(h_eff - 32'd1);
  end

  // CPU clock phase counter, toggling, strobes and turbo latch on rising edges.
  always_comb begin
    hcnt_d      = hcnt_q + HW'(1);
    clk_cpu_d   = clk_cpu_q;
    cpu_pos_d   = 1'b0;
    cpu_neg_d   = 1'b0;
    turbo_act_d = turbo_act_q;
    if (hcnt_q == h_last) begin
      if (stall_hold) begin
        hcnt_d = hcnt_q;
      end else begin
        hcnt_d    = '0;
        clk_cpu_d = ~clk_cpu_q;
        if (!clk_cpu_q) begin
          cpu_pos_d   = 1'b1;
          turbo_act_d = bus.turbo;
        end else begin
          cpu_neg_d = 1'b1;
        end
      end
    end
  end

  // Base-rate T-state counter and interrupt window; immune to turbo and stall.
  always_comb begin
    base_tick = (bcnt_q == BW'(2 * HALF_BASE - 1));
    bcnt_d    = base_tick ? '0 : bcnt_q + BW'(1);
    tstate_d  = tstate_q;
    if (base_tick) begin
      tstate_d = (tstate_q == TW'(FRAME_T - 1)) ? '0 : tstate_q + TW'(1);
    end
    vs_nintr_d = !(tstate_q < TW'(INT_LEN));
  end

  // Free-running PSG enable divider.
  always_comb begin
    psg_en_d = (pcnt_q == PW'(PSG_DIV - 1));
    pcnt_d   = psg_en_d ? '0 : pcnt_q + PW'(1);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_sys) begin
    if (!nRESET) begin
      hcnt_q      <= '0;
      clk_cpu_q   <= 1'b0;
      cpu_pos_q   <= 1'b0;
      cpu_neg_q   <= 1'b0;
      turbo_act_q <= '0;
      bcnt_q      <= '0;
      tstate_q    <= '0;
      vs_nintr_q  <= 1'b1;
      pcnt_q      <= '0;
      psg_en_q    <= 1'b0;
    end else begin
      hcnt_q      <= hcnt_d;
      clk_cpu_q   <= clk_cpu_d;
      cpu_pos_q   <= cpu_pos_d;
      cpu_neg_q   <= cpu_neg_d;
      turbo_act_q <= turbo_act_d;
      bcnt_q      <= bcnt_d;
      tstate_q    <= tstate_d;
      vs_nintr_q  <= vs_nintr_d;
      pcnt_q      <= pcnt_d;
      psg_en_q    <= psg_en_d;
    end
  end

  assign bus.clk_cpu   = clk_cpu_q;
  assign bus.cpu_pos   = cpu_pos_q;
  assign bus.cpu_neg   = cpu_neg_q;
  assign bus.psg_en    = psg_en_q;
  assign bus.tstate    = tstate_q;
  assign bus.vs_nintr  = vs_nintr_q;
  assign bus.turbo_act = turbo_act_q;

endmodule

// File: tb/tb_cpu_clkgen.sv
// Bench for cpu_clkgen: a default-parameter instance plus a short-frame instance,
// both checked every cycle against a deadline-based behavioural model.
module tb_cpu_clkgen;

  localparam int HB   = 4;
  localparam int PSG  = 16;
  localparam int FT   = 69888;
  localparam int IL   = 32;
  localparam int S_FT = 10;
  localparam int S_IL = 2;

`ifdef CPUCLK_CONTENTION_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic [1:0] turbo = 2'd0;
  logic       stall = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_pos = -1;
  int last_neg = -1;

  always #5 clk = ~clk;

  cpu_clkgen_if #(.TURBO_W(2), .TW(17)) bus_big ();
  cpu_clkgen_if #(.TURBO_W(2), .TW(4))  bus_sml ();

  assign bus_big.turbo = turbo;
  assign bus_big.stall = stall;
  assign bus_sml.turbo = turbo;
  assign bus_sml.stall = stall;

  cpu_clkgen #(
    .HALF_BASE(HB), .TURBO_W(2), .PSG_DIV(PSG), .FRAME_T(FT), .INT_LEN(IL), .TW(17)
  ) u_big (
    .clk_sys(clk),
    .nRESET (nrst),
    .bus    (bus_big)
  );

  cpu_clkgen #(
    .HALF_BASE(HB), .TURBO_W(2), .PSG_DIV(PSG), .FRAME_T(S_FT), .INT_LEN(S_IL), .TW(4)
  ) u_sml (
    .clk_sys(clk),
    .nRESET (nrst),
    .bus    (bus_sml)
  );

  // Behavioural model: n = cycles since reset release; CPU edges as absolute deadlines.
  int       n = 0;
  bit       m_lvl = 0, m_pos = 0, m_neg = 0;
  bit [1:0] m_act = 0;
  int       m_len = HB;
  int       m_due = HB;

  function automatic int half_of(input int t);
    int x;
    x = HB >> t;
    return (x == 0) ? 1 : x;
  endfunction

  function automatic int exp_ts(input int k, input int frame);
    return (k / (2 * HB)) % frame;
  endfunction

  function automatic int exp_vs(input int k, input int frame, input int il);
    if (k == 0) return 1;
    return (exp_ts(k - 1, frame) >= il) ? 1 : 0;
  endfunction

  function automatic int exp_psg(input int k);
    return (k > 0 && (k % PSG) == 0) ? 1 : 0;
  endfunction

  task automatic model_update();
    if (!nrst) begin
      n = 0; m_lvl = 0; m_pos = 0; m_neg = 0; m_act = 0; m_len = HB; m_due = HB;
    end else begin
      n++;
      m_pos = 0; m_neg = 0;
      if (n == m_due) begin
        if (m_lvl && STALL_EN && stall) begin
          m_due = n + 1;
        end else if (!m_lvl) begin
          m_lvl = 1; m_pos = 1; m_act = turbo;
          m_len = half_of(int'(turbo));
          m_due = n + m_len;
        end else begin
          m_lvl = 0; m_neg = 1;
          m_due = n + m_len;
        end
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    cyc++;
    if (bus_big.cpu_pos === 1'b1) last_pos = cyc;
    if (bus_big.cpu_neg === 1'b1) last_neg = cyc;
    check("clk_cpu",   32'(bus_big.clk_cpu),   32'(m_lvl));
    check("cpu_pos",   32'(bus_big.cpu_pos),   32'(m_pos));
    check("cpu_neg",   32'(bus_big.cpu_neg),   32'(m_neg));
    check("turbo_act", 32'(bus_big.turbo_act), 32'(m_act));
    check("psg_en",    32'(bus_big.psg_en),    32'(exp_psg(n)));
    check("tstate",    32'(bus_big.tstate),    32'(exp_ts(n, FT)));
    check("vs_nintr",  32'(bus_big.vs_nintr),  32'(exp_vs(n, FT, IL)));
    check("s_clk_cpu", 32'(bus_sml.clk_cpu),   32'(m_lvl));
    check("s_tstate",  32'(bus_sml.tstate),    32'(exp_ts(n, S_FT)));
    check("s_vs",      32'(bus_sml.vs_nintr),  32'(exp_vs(n, S_FT, S_IL)));
  endtask

  task automatic wait_pos(output int at);
    int start;
    start = last_pos;
    at = -1;
    for (int i = 0; i < 100; i++) begin
      step();
      if (last_pos != start) begin
        at = last_pos;
        break;
      end
    end
    if (at < 0) check("wait_pos_timeout", 32'd0, 32'd1);
  endtask

  typedef struct {
    int cyc;
    bit clk_cpu, pos, neg, psg, vs;
    int ts;
  } vec_t;

  initial begin
    vec_t vecs[8];
    int rel, p0, p1, p2, p3, p4, q, low_cnt, wraps0, wraps1, prev_ts;

    vecs[0] = '{0,  0, 0, 0, 0, 1, 0};
    vecs[1] = '{1,  0, 0, 0, 0, 0, 0};
    vecs[2] = '{4,  1, 1, 0, 0, 0, 0};
    vecs[3] = '{8,  0, 0, 1, 0, 0, 1};
    vecs[4] = '{12, 1, 1, 0, 0, 0, 1};
    vecs[5] = '{16, 0, 0, 1, 1, 0, 2};
    vecs[6] = '{17, 0, 0, 0, 0, 0, 2};
    vecs[7] = '{32, 0, 0, 1, 1, 0, 4};

    // Startup: reset held 5 cycles, then released with turbo 0.
    nrst = 0; turbo = 0; stall = 0;
    for (int i = 0; i < 5; i++) step();
    rel = 0;
    foreach (vecs[i]) begin
      while (rel < vecs[i].cyc) begin
        if (rel == 0) nrst = 1;
        step();
        rel++;
      end
      check("tbl_clk_cpu",  32'(bus_big.clk_cpu),  32'(vecs[i].clk_cpu));
      check("tbl_cpu_pos",  32'(bus_big.cpu_pos),  32'(vecs[i].pos));
      check("tbl_cpu_neg",  32'(bus_big.cpu_neg),  32'(vecs[i].neg));
      check("tbl_psg_en",   32'(bus_big.psg_en),   32'(vecs[i].psg));
      check("tbl_vs_nintr", 32'(bus_big.vs_nintr), 32'(vecs[i].vs));
      check("tbl_tstate",   32'(bus_big.tstate),   32'(vecs[i].ts));
    end

    // Turbo change mid high phase waits for the next rising edge.
    wait_pos(p0);
    step();
    turbo = 2'd1;
    wait_pos(p1);
    check("turbo_cur_period", 32'(p1 - p0), 32'd8);
    check("turbo_act_1", 32'(bus_big.turbo_act), 32'd1);
    wait_pos(p2);
    check("turbo1_period", 32'(p2 - p1), 32'd4);
    turbo = 2'd3;
    wait_pos(p3);
    check("turbo3_first", 32'(p3 - p2), 32'd4);
    check("turbo_act_3", 32'(bus_big.turbo_act), 32'd3);
    wait_pos(p4);
    check("turbo3_period", 32'(p4 - p3), 32'd2);

    // Stall for 6 cycles starting on the last high-phase cycle at 1x.
    turbo = 2'd0;
    wait_pos(p0);
    wait_pos(p0);
    for (int i = 0; i < 3; i++) step();
    stall = 1;
    for (int i = 0; i < 6; i++) step();
    stall = 0;
    for (int i = 0; i < 10 && last_neg <= p0; i++) step();
    check("stall_high_len", 32'(last_neg - p0), STALL_EN ? 32'd10 : 32'd4);

    // Reset asserted during a stall at turbo 2.
    turbo = 2'd2;
    wait_pos(p0);
    wait_pos(p0);
    check("turbo_act_2", 32'(bus_big.turbo_act), 32'd2);
    stall = 1;
    for (int i = 0; i < 3; i++) step();
    nrst = 0;
    step();
    check("rst_clk_cpu",   32'(bus_big.clk_cpu),   32'd0);
    check("rst_tstate",    32'(bus_big.tstate),    32'd0);
    check("rst_turbo_act", 32'(bus_big.turbo_act), 32'd0);
    check("rst_pos_neg",   32'({bus_big.cpu_pos, bus_big.cpu_neg}), 32'd0);
    check("rst_vs_nintr",  32'(bus_big.vs_nintr),  32'd1);
    step();
    stall = 0; turbo = 0; nrst = 1;

    // Randomized turbo, stall and occasional reset against the model.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 19) == 0) turbo = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) stall = ~stall;
      nrst = ($urandom_range(0, 599) != 0);
      step();
    end

    // Short frame: tstate wraps every 80 cycles, vs_nintr low 16 cycles per frame.
    stall = 0; turbo = 0; nrst = 0;
    step(); step();
    nrst = 1;
    low_cnt = 0; wraps0 = -1; wraps1 = -1; prev_ts = 0;
    for (int k = 1; k <= 170; k++) begin
      step();
      if (k <= 80 && bus_sml.vs_nintr == 1'b0) low_cnt++;
      if (prev_ts == S_FT - 1 && int'(bus_sml.tstate) == 0) begin
        if (wraps0 < 0) wraps0 = k;
        else if (wraps1 < 0) wraps1 = k;
      end
      prev_ts = int'(bus_sml.tstate);
    end
    check("frame_vs_low", 32'(low_cnt), 32'd16);
    check("frame_wrap0",  32'(wraps0),  32'd80);
    check("frame_wrap1",  32'(wraps1),  32'd160);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
